// File: rtl/lagd_spi_host.sv
// SPI mode-0 master turning 32-bit word read/write requests into bridge frames.
// Latency: ClkDiv*(2*(72+dummy)+2) + 1 cycles from accept to rsp_valid_o; CsGap more to ready.
// Backpressure: one request at a time; req_ready_o is low from accept until the CS gap ends.
module lagd_spi_host #(
  parameter int unsigned ClkDiv      = 4,
  parameter int unsigned DummyCycles = 32,
  parameter logic [7:0]  CmdWrite    = 8'h02,
  parameter logic [7:0]  CmdRead     = 8'h0B,
  parameter int unsigned CsGap       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SETUP = 4'd1;
  localparam logic [3:0] S_CMD   = 4'd2;
  localparam logic [3:0] S_ADDR  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_DUMMY = 4'd5;
  localparam logic [3:0] S_RDATA = 4'd6;
  localparam logic [3:0] S_HOLD  = 4'd7;
  localparam logic [3:0] S_GAP   = 4'd8;

  localparam logic [7:0]  DivLast = 8'(ClkDiv - 1);
  localparam logic [5:0]  DumLast = 6'((DummyCycles == 0) ? 0 : DummyCycles - 1);
  localparam logic [15:0] GapLast = 16'(CsGap - 1);

  logic [3:0]  r_state;
  logic [7:0]  r_div;
  logic [5:0]  r_bit;
  logic [15:0] r_gap;
  logic        r_sck;
  logic        r_csn;
  logic        r_mosi;
  logic        r_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_rsp_vld;
  logic [31:0] r_rsp_dat;

  logic        w_wrap;
  logic        w_shift;
  logic        w_rise;
  logic        w_fall;
  logic [7:0]  w_cmd;

  assign w_wrap  = (r_div == DivLast);
  assign w_shift = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_WDATA) ||
                   (r_state == S_DUMMY) || (r_state == S_RDATA);
  assign w_rise  = w_shift && w_wrap && !r_sck;
  assign w_fall  = w_shift && w_wrap && r_sck;
  assign w_cmd   = req_we_i ? CmdWrite : CmdRead;

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_vld;
  assign rsp_rdata_o = r_rsp_dat;
  assign busy_o      = (r_state != S_IDLE);
  assign spi_sck_o   = r_sck;
  assign spi_csn_o   = r_csn;
  assign spi_mosi_o  = r_mosi;

  // Frame sequencer: divider, SCK generation, bit shifting and phase transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_sck     <= 1'b0;
      r_csn     <= 1'b1;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (req_valid_i && r_ready) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_tx    <= {w_cmd, 24'd0};
            r_mosi  <= w_cmd[7];
            r_csn   <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_SETUP;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
          if (w_wrap) begin
            r_bit   <= 6'd7;
            r_state <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA: begin
          r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
          if (w_wrap) r_sck <= ~r_sck;
          if (w_rise && (r_state == S_RDATA)) r_rx <= {r_rx[30:0], spi_miso_i};
          if (w_fall) begin
            if (r_bit != 6'd0) begin
              r_bit  <= r_bit - 6'd1;
              r_tx   <= r_tx << 1;
              r_mosi <= r_tx[30];
            end else begin
              // Last falling edge of a phase flows straight into the next phase.
              r_bit  <= 6'd31;
              r_tx   <= '0;
              r_mosi <= 1'b0;
              case (r_state)
                S_CMD: begin
                  r_tx    <= r_addr;
                  r_mosi  <= r_addr[31];
                  r_state <= S_ADDR;
                end
                S_ADDR: begin
                  if (r_we) begin
                    r_tx    <= r_wdata;
                    r_mosi  <= r_wdata[31];
                    r_state <= S_WDATA;
                  end else if (DummyCycles == 0) begin
                    r_state <= S_RDATA;
                  end else begin
                    r_bit   <= DumLast;
                    r_state <= S_DUMMY;
                  end
                end
                S_DUMMY: r_state <= S_RDATA;
                default: r_state <= S_HOLD;
              endcase
            end
          end
        end
        S_HOLD: begin
          r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
          if (w_wrap) begin
            r_csn     <= 1'b1;
            r_rsp_vld <= 1'b1;
            r_rsp_dat <= r_we ? 32'd0 : r_rx;
            r_gap     <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + 16'd1;
          if (r_gap == GapLast) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lagd_spi_host.md
Name: lagd_spi_host

Overview:
- Single-lane SPI master (mode 0, CPOL=0/CPHA=0, MSB first).
- Turns 32-bit word write/read requests into SPI frames addressed to the SoC's SPI-slave-to-AXI bridge.
- Used in the host/FPGA harness and as an on-die loopback initiator for bring-up. It drives spi_sck, spi_cs and sdi[0] of the chip, and samples sdo[0].
- Unused bridge lanes [3:1] are left to the harness.

Parameters:
- ClkDiv, 4, SCK half-period in clk_i cycles; legal 1..255.
- DummyCycles, 32, SCK cycles between address and read data; legal 0..63.
- CmdWrite, 8'h02, command byte for a word write.
- CmdRead, 8'h0B, command byte for a word read.
- CsGap, 2, clk_i cycles that CS stays high between frames; legal ≥1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  bridge byte address
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  one-cycle pulse at transaction end
- rsp_rdata_o  out  32  read data; 0 for writes; held until next rsp
- busy_o  out  1  frame in progress
- spi_sck_o  out  1  SPI clock, idle low
- spi_csn_o  out  1  chip select, active-low, idle high
- spi_mosi_o  out  1  master-out data
- spi_miso_i  in  1  master-in data

Behaviour:
- Reset (sync, rst_i=1 at posedge):
  - FSM goes to IDLE; divider and bit counters clear.
  - Output reset values: spi_sck_o=0, spi_csn_o=1, spi_mosi_o=0, req_ready_o=0 during reset, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0.
  - Reset mid-frame aborts immediately: CS deasserts next cycle and no rsp is produced.
- Handshake:
  - req_ready_o=1 only in IDLE. Accept on valid&ready and latch we/addr/wdata.
  - Requests are not queued. req_ready_o drops the cycle after acceptance and stays low until rsp_valid_o has pulsed and CsGap has elapsed.
- FSM states:
  - IDLE -> SETUP on accept.
  - SETUP: csn=0 and mosi=MSB of the command. Lasts ClkDiv cycles.
  - CMD: 8 bits.
  - ADDR: 32 bits.
  - Write path: ADDR -> WDATA (32 bits) -> HOLD.
  - Read path: ADDR -> DUMMY (DummyCycles SCK cycles; skipped if 0) -> RDATA (32 bits) -> HOLD.
  - HOLD: sck=0 for ClkDiv cycles, then csn=1 and rsp_valid_o pulses for 1 cycle.
  - GAP: CsGap cycles -> IDLE.
- Bit timing:
  - Divider counts 0..ClkDiv-1. sck toggles at wrap.
  - Each bit is 2*ClkDiv clk_i cycles: low phase then high phase.
  - mosi updates on the sck falling edge (and at SETUP for the first bit).
  - miso is sampled in the cycle sck rises, during RDATA only, shifting left into a 32-bit register.
  - After the last rising edge of a phase, the falling edge moves to the next phase without a gap.
  - mosi=0 during DUMMY and RDATA.
- Frame length:
  - Write: 72 SCK cycles.
  - Read: 72+DummyCycles SCK cycles.
  - With defaults, a write holds csn low for ClkDiv + 72*2*ClkDiv + ClkDiv = 584 cycles.
- Response:
  - Read: rsp_rdata_o = shifted word, updated in the rsp_valid_o cycle.
  - Write: rsp_rdata_o = 0.
- busy_o = (state != IDLE).
- Counters:
  - Bit counter is 6 bits and reloads per phase. A dummy count of 0 skips the DUMMY state.
  - The divider counter width is 8 bits, so there is no wrap issue for ClkDiv ≤ 255.
- Requests with valid held while not ready are ignored and must stay stable (AXI-style). The block does not check this.

Test Plan:
- Write, defaults: addr=0x7000_0010, wdata=0xDEAD_BEEF.
  - MOSI over 72 rising edges = 0x02, 0x70000010, 0xDEADBEEF.
  - csn low for 584 cycles; rsp_valid 1 pulse with rdata=0.
- Read, defaults: addr=0x7000_0000; bench slave drives 0x1234_5678 MSB first on falling edges after 8+32+32 SCK cycles.
  - rsp_rdata_o=0x12345678; 104 SCK rising edges counted.
- DummyCycles=0, ClkDiv=1: read 0xA5A5_0F0F.
  - 72 SCK cycles; each SCK period is 2 clk; data correct.
- Back-to-back: hold req_valid high with 2 writes.
  - Second accept exactly CsGap cycles after the first rsp pulse; csn high ≥2 cycles between frames.
- Reset mid-ADDR: assert rst_i at bit 20 of the address.
  - Next cycle csn=1, sck=0, no rsp; req_ready=1 the cycle after rst_i drops.
- Idle/stall: req_valid=0 for 100 cycles.
  - sck=0, csn=1, mosi=0 throughout; ready=1.
